// File: rtl/vscale_htif_pcr_arbiter_if.sv
// Requester-side and HTIF-side PCR channel signals for the PCR arbiter.
// The arbiter takes the slave view; the host environment takes the master view.
interface vscale_htif_pcr_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_rw;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            resp_valid;
   logic [NUM_REQ-1:0]            resp_ready;
   logic [DATA_WIDTH-1:0]         resp_data;

   logic                          htif_pcr_req_valid;
   logic                          htif_pcr_req_ready;
   logic                          htif_pcr_req_rw;
   logic [ADDR_WIDTH-1:0]         htif_pcr_req_addr;
   logic [DATA_WIDTH-1:0]         htif_pcr_req_data;
   logic                          htif_pcr_resp_valid;
   logic                          htif_pcr_resp_ready;
   logic [DATA_WIDTH-1:0]         htif_pcr_resp_data;

   modport slave (
      input  req_valid, req_rw, req_addr, req_data, resp_ready,
      input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
      output req_ready, resp_valid, resp_data,
      output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
      output htif_pcr_resp_ready
   );

   modport master (
      output req_valid, req_rw, req_addr, req_data, resp_ready,
      output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
      input  req_ready, resp_valid, resp_data,
      input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
      input  htif_pcr_resp_ready
   );
endinterface

// File: rtl/vscale_htif_pcr_arbiter.sv
// Round-robin arbiter sharing one HTIF PCR request/response channel between
// NUM_REQ host-side requesters, one outstanding transaction at a time.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a requester; winner accepted combinationally
//   REQ   | latched request presented to the HTIF until it is accepted
//   RESP  | HTIF response passed through to the granted requester
module vscale_htif_pcr_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   vscale_htif_pcr_arbiter_if.slave              bus,
   output logic                                  busy,
   output logic [ID_WIDTH-1:0]                   grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   winner;
   logic [ID_WIDTH-1:0]   cand;
   logic                  found;
   logic                  lat_rw;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_data;
   logic                  resp_done;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign resp_done = (state == RESP) && bus.htif_pcr_resp_valid && bus.resp_ready[grant_id];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         lat_rw   <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && found) begin
            grant_id <= winner;
            lat_rw   <= bus.req_rw[winner];
            lat_addr <= bus.req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            lat_data <= bus.req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
         end
         if (resp_done) begin
            rr_ptr <= ID_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
         end
      end
   end

   // req_ready is gated by reset so nothing is accepted that reset would discard.
   always_comb begin
      state_next              = state;
      bus.req_ready           = '0;
      bus.resp_valid          = '0;
      bus.resp_data           = '0;
      bus.htif_pcr_req_valid  = 1'b0;
      bus.htif_pcr_resp_ready = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               bus.req_ready[winner] = reset;
               state_next            = REQ;
            end
         end
         REQ: begin
            bus.htif_pcr_req_valid = 1'b1;
            if (bus.htif_pcr_req_ready) state_next = RESP;
         end
         RESP: begin
            bus.resp_valid[grant_id] = bus.htif_pcr_resp_valid;
            bus.resp_data            = bus.htif_pcr_resp_data;
            bus.htif_pcr_resp_ready  = bus.resp_ready[grant_id];
            if (resp_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.htif_pcr_req_rw   = lat_rw;
   assign bus.htif_pcr_req_addr = lat_addr;
   assign bus.htif_pcr_req_data = lat_data;
   assign busy                  = (state != IDLE);

endmodule
